// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC sequence, issues word
// aligned requests to instruction memory under a credit limit, buffers
// returned words with their PCs in a small FIFO for decode, and discards
// stale responses after a redirect.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } mode_t;

  mode_t mode_q, mode_d;

  logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_d;
  logic [DATA_WIDTH-1:0] rsp_pc, rsp_pc_d;
  logic [CW-1:0]         outstanding, outstanding_d;
  logic [CW-1:0]         drop_cnt, drop_cnt_d;
  logic [CW-1:0]         count, count_d;
  logic [PW-1:0]         rd_ptr, rd_ptr_d;
  logic [PW-1:0]         wr_ptr, wr_ptr_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc   [DEPTH];

  logic [CW:0]           credit_used;
  logic                  req_fire;
  logic                  discard;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] redirect_base;
  logic                  unused_redirect_lsbs;

  assign redirect_base        = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Mode register: FLUSH while stale responses remain to be dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) mode_q <= FETCH;
    else      mode_q <= mode_d;
  end

  // Next mode follows the updated drop counter.
  always_comb begin
    mode_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
  end

  // Handshake outputs and per-cycle events; reset gates the request and
  // delivery valids combinationally so they drop as soon as RST falls.
  always_comb begin
    credit_used    = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = RST && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    discard        = (mode_q == FLUSH) || redirect_valid;
    push           = imem_rsp_valid && !discard;
    instr_valid    = RST && !redirect_valid && (count != '0);
    pop            = instr_valid && instr_ready;
    instr          = mem_data[rd_ptr];
    instr_pc       = mem_pc[rd_ptr];
  end

  // Next-state datapath: PCs, credit/drop counters, FIFO occupancy.
  always_comb begin
    fetch_pc_d    = fetch_pc;
    rsp_pc_d      = rsp_pc;
    outstanding_d = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt;
    count_d       = count;
    rd_ptr_d      = rd_ptr;
    wr_ptr_d      = wr_ptr;
    if (redirect_valid) begin
      // Every fetch still in flight (minus the one returning now, which is
      // discarded directly) belongs to a stale path; this also absorbs any
      // drop count left over from an earlier redirect.
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_cnt_d = outstanding - CW'(imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc + DATA_WIDTH'(4);
      if (push)     rsp_pc_d   = rsp_pc + DATA_WIDTH'(4);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_d = drop_cnt - CW'(1);
      count_d  = count + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr + PW'(push);
      rd_ptr_d = rd_ptr + PW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_d;
      rsp_pc      <= rsp_pc_d;
      outstanding <= outstanding_d;
      drop_cnt    <= drop_cnt_d;
      count       <= count_d;
      rd_ptr      <= rd_ptr_d;
      wr_ptr      <= wr_ptr_d;
    end
  end

  // FIFO storage: kept responses written with their PC.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// of programmable latency and a log of delivered (pc, word) pairs.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready    = 1'b0;

  fetch_unit #(
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] dl_pc[$];
  logic [31:0] dl_data[$];
  int unsigned lat   = 1;
  int unsigned cyc   = 0;
  int unsigned n_req = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_delivered(input string tag, input int unsigned idx, input logic [31:0] pc);
    check_eq({tag, "_seen"}, 32'(dl_pc.size() > int'(idx)), 32'd1);
    if (dl_pc.size() > int'(idx)) begin
      check_eq({tag, "_pc"}, dl_pc[idx], pc);
      check_eq({tag, "_data"}, dl_data[idx], word_of(pc));
    end
  endtask

  // One clock cycle: record accepted requests, consumed responses and
  // deliveries at mid-cycle, then drive the memory response for the next.
  task automatic cycle();
    @(negedge CLK);
    if (RST && imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      n_req++;
    end
    if (imem_rsp_valid && mq.size() != 0) void'(mq.pop_front());
    if (instr_valid && instr_ready) begin
      dl_pc.push_back(instr_pc);
      dl_data.push_back(instr);
    end
    @(posedge CLK);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Asserts reset just after an edge, checks outputs drop at once, then
  // releases; returns in the first cycle after release.
  task automatic do_reset(input int unsigned latency, input logic ready);
    @(posedge CLK);
    #1;
    RST            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    dl_pc.delete();
    dl_data.delete();
    n_req       = 0;
    lat         = latency;
    instr_ready = ready;
    #1;
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    check_eq("rel_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("rel_req_addr", imem_req_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming: 1-cycle memory, decode always ready.
    do_reset(1, 1'b1);
    check_eq("t1_instr_valid0", 32'(instr_valid), 32'd0);
    cycle(); #1;
    check_eq("t1_req_addr1", imem_req_addr, 32'h4);
    check_eq("t1_instr_valid1", 32'(instr_valid), 32'd0);
    cycle(); #1;
    check_eq("t1_instr_valid2", 32'(instr_valid), 32'd1);
    check_eq("t1_pc2", instr_pc, 32'h0);
    check_eq("t1_instr2", instr, word_of(32'h0));
    check_eq("t1_req_addr2", imem_req_addr, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      cycle(); #1;
      check_eq("t1_stream_valid", 32'(instr_valid), 32'd1);
      check_eq("t1_stream_pc", instr_pc, 32'(4 * k));
    end

    // Backpressure: credit limit caps fetches at DEPTH.
    do_reset(1, 1'b0);
    repeat (10) cycle();
    #1;
    check_eq("t2_n_req", 32'(n_req), 32'd4);
    check_eq("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t2_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (8) cycle();
    for (int k = 0; k < 5; k++) check_delivered("t2_order", k, 32'(4 * k));

    // Redirect with three fetches in flight and none returning this cycle.
    do_reset(4, 1'b1);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check_eq("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    cycle(); #1;
    check_eq("t3_req_addr", imem_req_addr, 32'h100);
    repeat (8) cycle();
    check_delivered("t3_first", 0, 32'h100);

    // Redirect coinciding with a response: exactly one more drop.
    do_reset(2, 1'b1);
    repeat (2) cycle();
    check_eq("t4_rsp_now", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle(); #1;
    check_eq("t4_req_addr", imem_req_addr, 32'h40);
    repeat (6) cycle();
    check_delivered("t4_first", 0, 32'h40);

    // Second redirect while still flushing the first.
    do_reset(4, 1'b1);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle(); #1;
    check_eq("t5_req_addr1", imem_req_addr, 32'h100);
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle(); #1;
    check_eq("t5_req_addr2", imem_req_addr, 32'h200);
    repeat (8) cycle();
    check_delivered("t5_first", 0, 32'h200);

    // Redirect with a full FIFO: head hidden and the pop ignored.
    do_reset(1, 1'b0);
    repeat (6) cycle();
    #1;
    check_eq("t6_full_valid", 32'(instr_valid), 32'd1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    check_eq("t6_valid_masked", 32'(instr_valid), 32'd0);
    cycle(); #1;
    check_eq("t6_req_addr", imem_req_addr, 32'h80);
    repeat (5) cycle();
    check_delivered("t6_first", 0, 32'h80);

    // Address wrap at the top of the space, then reset mid-burst.
    dl_pc.delete();
    dl_data.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle(); #1;
    check_eq("t7_req_top", imem_req_addr, 32'hFFFF_FFFC);
    cycle(); #1;
    check_eq("t7_req_wrap", imem_req_addr, 32'h0);
    repeat (3) cycle();
    check_delivered("t7_top", 0, 32'hFFFF_FFFC);
    check_delivered("t7_wrap", 1, 32'h0);
    #1;
    check_eq("t7_busy_valid", 32'(instr_valid), 32'd1);
    do_reset(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
